program_loader: RTL

//  Upstream feeder of the instruction fetch stage. Receives the program as a byte stream

---
 rtl/program_loader.sv | 98 +++++++++
 1 files changed

// File: rtl/program_loader.sv
// Streams received bytes into instruction memory and holds the fetch PC at 0 while loading.
// A load session ends when an aligned HALT word arrives, or with an error once memory is full.
module program_loader #(
  parameter int unsigned         NB_DATA   = 32,
  parameter int unsigned         NB_BYTE   = 8,
  parameter int unsigned         MEM_BYTES = 256,
  parameter logic [NB_DATA-1:0]  HALT_WORD = 32'hFFFF_FFFF,
  localparam int unsigned        NB_COUNT  = $clog2(MEM_BYTES + 1)
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_load_start,
  input  logic [NB_BYTE-1:0]  i_rx_byte,
  input  logic                i_rx_valid,
  output logic [NB_BYTE-1:0]  o_load_byte,
  output logic                o_load_write_enable,
  output logic                o_pc_reset,
  output logic                o_load_busy,
  output logic                o_load_done,
  output logic                o_load_error,
  output logic [NB_COUNT-1:0] o_byte_count
);

  localparam logic [NB_COUNT-1:0] MemBytesCnt  = NB_COUNT'(MEM_BYTES);
  localparam logic [NB_COUNT-1:0] BytesPerWord = NB_COUNT'(NB_DATA / NB_BYTE);

  typedef enum logic [1:0] {
    StIdle,
    StLoading,
    StDone,
    StError
  } state_e;

  state_e              r_state;
  logic [NB_BYTE-1:0]  r_load_byte;
  logic                r_write_enable;
  logic [NB_COUNT-1:0] r_byte_count;
  logic [NB_DATA-1:0]  r_word;

  logic [NB_COUNT-1:0] w_count_next;
  logic [NB_DATA-1:0]  w_word_next;
  logic                w_word_boundary;
  logic                w_halt_seen;
  logic                w_mem_full;

  // Oldest byte of the word ends up in the most significant position.
  assign w_count_next    = r_byte_count + NB_COUNT'(1);
  assign w_word_next     = {r_word[NB_DATA-NB_BYTE-1:0], i_rx_byte};
  assign w_word_boundary = ((w_count_next % BytesPerWord) == '0);
  assign w_halt_seen     = w_word_boundary && (w_word_next == HALT_WORD);
  assign w_mem_full      = (w_count_next == MemBytesCnt);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state        <= StIdle;
      r_load_byte    <= '0;
      r_write_enable <= 1'b0;
      r_byte_count   <= '0;
      r_word         <= '0;
    end else begin
      r_write_enable <= 1'b0;
      case (r_state)
        StIdle, StDone, StError: begin
          // A byte arriving together with the start pulse is dropped.
          if (i_load_start) begin
            r_state      <= StLoading;
            r_byte_count <= '0;
            r_word       <= '0;
          end
        end
        StLoading: begin
          if (i_rx_valid) begin
            r_load_byte    <= i_rx_byte;
            r_write_enable <= 1'b1;
            r_byte_count   <= w_count_next;
            r_word         <= w_word_next;
            // HALT filling the last slot still counts as a clean finish.
            if (w_halt_seen) begin
              r_state <= StDone;
            end else if (w_mem_full) begin
              r_state <= StError;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_load_byte         = r_load_byte;
  assign o_load_write_enable = r_write_enable;
  assign o_byte_count        = r_byte_count;
  assign o_pc_reset          = (r_state == StLoading);
  assign o_load_busy         = (r_state == StLoading);
  assign o_load_done         = (r_state == StDone);
  assign o_load_error        = (r_state == StError);

endmodule
